// File: rtl/conv_op_collector.sv
// conv_op_collector: captures one convolver output window, rescales and
// saturates each result to 16 bits, then drains it over a valid/ready stream.
// Optional build macro RELU_EN: clamp negative stored results to zero.
module conv_op_collector #(
    parameter int N       = 10,
    parameter int K       = 5,
    parameter int C_SIZE  = 32,
    parameter int Q_SHIFT = 8
) (
    input  logic              clk,
    input  logic              global_rst_n,
    input  logic              ce,
    input  logic [C_SIZE-1:0] conv_op,
    input  logic              valid_conv,
    input  logic              end_conv,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [15:0]       rd_data,
    output logic              rd_last,
    output logic              done,
    output logic [7:0]        sat_cnt,
    output logic              overrun
);

    localparam int M  = (N - K + 1) * (N - K + 1);
    localparam int PW = $clog2(M + 1);

    localparam logic signed [C_SIZE-1:0] SAT_HI = C_SIZE'(32767);
    localparam logic signed [C_SIZE-1:0] SAT_LO = C_SIZE'(-32768);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    state_t          state;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [15:0]     mem [M];

    logic signed [C_SIZE-1:0] shifted;
    logic                     clamp;
    logic [15:0]              res;
    logic                     idle_store;
    logic                     cap_valid;
    logic                     room;
    logic                     we;
    logic [PW-1:0]            wr_addr;
    logic [7:0]               sat_inc;

    // Rescale the incoming accumulator and clamp it into 16-bit range.
    always_comb begin
        shifted = $signed(conv_op) >>> Q_SHIFT;
        clamp   = 1'b0;
        res     = shifted[15:0];
        if (shifted > SAT_HI) begin
            res   = 16'h7FFF;
            clamp = 1'b1;
        end else if (shifted < SAT_LO) begin
            res   = 16'h8000;
            clamp = 1'b1;
        end
`ifdef RELU_EN
        if (res[15]) begin
            res = 16'h0000;
        end
`endif
    end

    // Write-side qualification: the IDLE->CAPTURE edge may already store entry 0.
    always_comb begin
        idle_store = (state == IDLE) && ce && valid_conv && !end_conv;
        cap_valid  = (state == CAPTURE) && ce && valid_conv && !end_conv;
        room       = wr_ptr < PW'(M);
        we         = idle_store || (cap_valid && room);
        wr_addr    = idle_store ? '0 : wr_ptr;
        sat_inc    = (sat_cnt == 8'hFF) ? sat_cnt : sat_cnt + 8'd1;
    end

    // Zero-latency read port; outputs forced low outside an active drain.
    always_comb begin
        rd_data = rd_valid ? mem[rd_ptr] : 16'h0000;
        rd_last = rd_valid && (rd_ptr == wr_ptr - 1'b1);
    end

    // Result buffer, contents not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= res;
        end
    end

    // Capture/drain control with registered status outputs.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            sat_cnt  <= 8'd0;
            overrun  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ce) begin
                        state   <= CAPTURE;
                        wr_ptr  <= idle_store ? PW'(1) : '0;
                        sat_cnt <= (idle_store && clamp) ? 8'd1 : 8'd0;
                        overrun <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (ce && end_conv) begin
                        if (wr_ptr != '0) begin
                            state    <= DRAIN;
                            rd_ptr   <= '0;
                            rd_valid <= 1'b1;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end else if (cap_valid) begin
                        if (room) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (clamp) begin
                                sat_cnt <= sat_inc;
                            end
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (ce && valid_conv) begin
                        overrun <= 1'b1;
                    end
                    if (rd_valid && rd_ready) begin
                        if (rd_last) begin
                            state    <= IDLE;
                            rd_ptr   <= '0;
                            rd_valid <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_op_collector.sv
// tb_conv_op_collector: scoreboard bench for the convolver output collector.
// Reference model rescales with plain integer arithmetic; monitor checks drain.
module tb_conv_op_collector;

    logic        clk;
    logic        global_rst_n;
    logic        ce;
    logic [31:0] conv_op;
    logic        valid_conv;
    logic        end_conv;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_last;
    logic        done;
    logic [7:0]  sat_cnt;
    logic        overrun;

    conv_op_collector dut (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .ce           (ce),
        .conv_op      (conv_op),
        .valid_conv   (valid_conv),
        .end_conv     (end_conv),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .done         (done),
        .sat_cnt      (sat_cnt),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        bit          l;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] stim[$];
    int          checks;
    int          failures;
    int          done_cnt;
    int          exp_sat;
    bit          exp_ovr;
    bit          empty_end;
    bit          expect_done;
    bit          prev_stall;
    logic [15:0] prev_data;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_val(input logic [31:0] x, output bit clamped);
        longint v;
        longint q;
        v = longint'($signed(x));
        q = v / 256;
        if (v < 0 && (v % 256) != 0) q = q - 1;
        clamped = 1'b0;
        if (q > 32767) begin
            q = 32767;
            clamped = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            clamped = 1'b1;
        end
`ifdef RELU_EN
        if (q < 0) q = 0;
`endif
        return 16'(q);
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] r;
        case ($urandom_range(0, 2))
            0: r = $urandom();
            1: r = $urandom_range(0, 32'h00FF_FFFF) - 32'h0080_0000;
            default: r = $urandom_range(0, 32'h007F_FFFF);
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented output against the scoreboard head.
    always @(negedge clk) begin
        bit nxt;
        nxt = 1'b0;
        if (!global_rst_n) begin
            expect_done = 1'b0;
            prev_stall  = 1'b0;
            empty_end   = 1'b0;
        end else begin
            if (done || expect_done) begin
                chk("done_pulse", done, expect_done);
            end
            if (done) done_cnt++;
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rd_valid", rd_valid, 0);
                end else begin
                    chk("rd_data", rd_data, sb[0].d);
                    chk("rd_last", rd_last, sb[0].l);
                    if (prev_stall) chk("stall_hold", rd_data, prev_data);
                    if (rd_ready) begin
                        if (sb[0].l) nxt = 1'b1;
                        void'(sb.pop_front());
                    end
                end
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            if (empty_end) begin
                nxt = 1'b1;
                empty_end = 1'b0;
            end
            expect_done = nxt;
        end
    end

    task automatic capture_phase(input bit end_with_valid);
        int n;
        int nst;
        bit cl;
        logic [15:0] r;
        n = stim.size();
        nst = (n > 36) ? 36 : n;
        exp_sat = 0;
        exp_ovr = (n > 36);
        ce = 1'b1; valid_conv = 1'b0; end_conv = 1'b0;
        step();
        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                conv_op = $urandom();
                if ($urandom_range(0, 1) == 1) begin
                    ce = 1'b0;
                    valid_conv = 1'($urandom_range(0, 1));
                    end_conv = 1'($urandom_range(0, 1));
                end else begin
                    ce = 1'b1; valid_conv = 1'b0; end_conv = 1'b0;
                end
                step();
            end
            ce = 1'b1; valid_conv = 1'b1; end_conv = 1'b0;
            conv_op = stim[i];
            if (i < nst) begin
                r = ref_val(stim[i], cl);
                sb.push_back('{d: r, l: (i == nst - 1)});
                if (cl) exp_sat++;
            end
            step();
        end
        ce = 1'b1; end_conv = 1'b1; valid_conv = end_with_valid;
        conv_op = $urandom();
        empty_end = (nst == 0);
        step();
        ce = 1'b0; valid_conv = 1'b0; end_conv = 1'b0;
    endtask

    task automatic drain_phase(input int rmode, input bit inj);
        int start;
        start = done_cnt;
        for (int c = 0; c < 400 && done_cnt == start; c++) begin
            case (rmode)
                0: rd_ready = 1'b1;
                1: rd_ready = (c % 3 == 0);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (inj && c == 2) begin
                ce = 1'b1; valid_conv = 1'b1; exp_ovr = 1'b1;
            end else begin
                ce = 1'b0; valid_conv = 1'b0;
            end
            step();
        end
        ce = 1'b0; valid_conv = 1'b0;
        chk("done_seen", done_cnt - start, 1);
        chk("sat_cnt", sat_cnt, exp_sat);
        chk("overrun", overrun, exp_ovr);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic window(input bit ewv, input int rmode, input bit inj);
        capture_phase(ewv);
        drain_phase(rmode, inj);
    endtask

    initial begin
        checks = 0; failures = 0; done_cnt = 0;
        empty_end = 1'b0; expect_done = 1'b0; prev_stall = 1'b0;
        ce = 1'b0; conv_op = '0; valid_conv = 1'b0; end_conv = 1'b0;
        rd_ready = 1'b0;
        global_rst_n = 1'b0;
        repeat (3) step();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_done", done, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        chk("rst_overrun", overrun, 0);
        global_rst_n = 1'b1;
        step();

        stim.delete();
        for (int i = 0; i < 36; i++) stim.push_back(32'(i) << 8);
        window(1'b0, 0, 1'b0);

        stim.delete();
        stim.push_back(32'h7FFF_0000);
        stim.push_back(32'h8000_0000);
        window(1'b0, 0, 1'b0);

        stim.delete();
        stim.push_back(32'hFFFF_FF00);
        window(1'b0, 0, 1'b0);

        stim.delete();
        for (int i = 0; i < 37; i++) begin
            stim.push_back(i < 36 ? rnd_val() : 32'h0000_1200);
        end
        window(1'b1, 2, 1'b0);

        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back(rnd_val());
        window(1'b0, 1, 1'b1);

        stim.delete();
        window(1'b1, 0, 1'b0);

        for (int w = 0; w < 6; w++) begin
            int n;
            n = $urandom_range(1, 36);
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(rnd_val());
            window(1'($urandom_range(0, 1)), $urandom_range(0, 2),
                   (n >= 4) && ($urandom_range(0, 1) == 1));
        end

        stim.delete();
        for (int i = 0; i < 10; i++) stim.push_back(32'h7F00_0000 + 32'(i));
        capture_phase(1'b0);
        rd_ready = 1'b0;
        repeat (3) step();
        chk("pre_rst_valid", rd_valid, 1);
        @(negedge clk);
        #2;
        global_rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_rd_last", rd_last, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sat_cnt", sat_cnt, 0);
        chk("mid_rst_overrun", overrun, 0);
        sb.delete();
        step();
        global_rst_n = 1'b1;
        step();

        stim.delete();
        for (int i = 0; i < 36; i++) stim.push_back(32'(i) << 8);
        window(1'b0, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
